// File: rtl/key_press_encoder_if.sv
// Press-event handshake between the key encoder (master) and the lock FSM (slave).
// key_code is held stable while key_valid is high and key_ready is low.
interface key_press_encoder_if;
   logic       key_valid;
   logic       key_ready;
   logic [1:0] key_code;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/key_press_encoder.sv
// Bouncy active-low buttons -> one priority-encoded event per press on a 1-entry valid/ready buffer.
// Latency DEBOUNCE_CYCLES+3 edges from pin; event held until key_ready, later presses meanwhile are dropped.
module key_press_encoder #(
   parameter int KEYS            = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [KEYS-1:0]            key_n,
   key_press_encoder_if.master        key_if,
   output logic                       key_held,
   output logic                       dropped
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, PENDING} state_t;

   logic [KEYS-1:0]      r_sync1;
   logic [KEYS-1:0]      r_sync2;
   logic [KEYS-1:0]      r_stable_n;
   logic [KEYS-1:0]      r_stable_d_n;
   logic [CNT_WIDTH-1:0] r_cnt [KEYS];
   logic                 r_key_held;

   state_t               r_state;
   logic                 r_valid;
   logic [1:0]           r_code;
   logic                 r_dropped;

   logic [KEYS-1:0]      w_stable_n_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt [KEYS];
   logic [KEYS-1:0]      w_evt;
   logic                 w_any;
   logic                 w_multi;
   logic [1:0]           w_code;

   // Any cycle where sync2 agrees with the stable state restarts the count.
   always_comb begin
      w_stable_n_nxt = r_stable_n;
      for (int i = 0; i < KEYS; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_sync2[i] != r_stable_n[i]) begin
            if (r_cnt[i] == CNT_MAX)
               w_stable_n_nxt[i] = r_sync2[i];
            else
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   assign w_evt   = r_stable_d_n & ~r_stable_n;
   assign w_any   = |w_evt;
   assign w_multi = |(w_evt & (w_evt - KEYS'(1)));

   always_comb begin
      w_code = '0;
      for (int i = KEYS - 1; i >= 0; i--) begin
         if (w_evt[i])
            w_code = 2'(i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1      <= '1;
         r_sync2      <= '1;
         r_stable_n   <= '1;
         r_stable_d_n <= '1;
         r_key_held   <= 1'b0;
         for (int i = 0; i < KEYS; i++)
            r_cnt[i] <= '0;
      end else begin
         r_sync1      <= key_n;
         r_sync2      <= r_sync1;
         r_stable_n   <= w_stable_n_nxt;
         r_stable_d_n <= r_stable_n;
         r_key_held   <= ~&w_stable_n_nxt;
         for (int i = 0; i < KEYS; i++)
            r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_valid   <= 1'b0;
         r_code    <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_dropped <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state   <= PENDING;
                  r_valid   <= 1'b1;
                  r_code    <= w_code;
                  r_dropped <= w_multi;
               end
            end
            PENDING: begin
               if (key_if.key_ready) begin
                  if (w_any) begin
                     r_code    <= w_code;
                     r_dropped <= w_multi;
                  end else begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
               end else if (w_any) begin
                  // Buffer is full: the old press wins, every new one is lost.
                  r_dropped <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign key_if.key_valid = r_valid;
   assign key_if.key_code  = r_code;
   assign key_held         = r_key_held;
   assign dropped          = r_dropped;

endmodule

// File: tb/tb_key_press_encoder.sv
// Directed bench for key_press_encoder with DEBOUNCE_CYCLES=4; edge N means the Nth posedge
// after inputs change, and outputs are sampled 1ns after that edge.
module tb_key_press_encoder;
   localparam int DC = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic       key_held;
   logic       dropped;

   int         errors = 0;
   int         checks = 0;
   int         n_acc = 0;
   logic [1:0] last_code = 2'd0;

   key_press_encoder_if kif ();

   key_press_encoder #(
      .KEYS(4),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .key_n    (key_n),
      .key_if   (kif),
      .key_held (key_held),
      .dropped  (dropped)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
         n_acc     <= n_acc + 1;
         last_code <= kif.key_code;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      kif.key_ready = 1'b0;
      tick(3);
      chk("rst_valid",   32'(kif.key_valid), 0);
      chk("rst_code",    32'(kif.key_code),  0);
      chk("rst_held",    32'(key_held),      0);
      chk("rst_dropped", 32'(dropped),       0);
      reset = 1'b1;
      tick(2);

      // 1: single clean press of key 1
      kif.key_ready = 1'b1;
      key_n = 4'b1101;
      tick(5);
      chk("t1_held_e5",  32'(key_held),      0);
      chk("t1_valid_e5", 32'(kif.key_valid), 0);
      tick();
      chk("t1_held_e6",  32'(key_held),      1);
      chk("t1_valid_e6", 32'(kif.key_valid), 0);
      tick();
      chk("t1_valid_e7", 32'(kif.key_valid), 1);
      chk("t1_code_e7",  32'(kif.key_code),  1);
      tick();
      chk("t1_valid_e8", 32'(kif.key_valid), 0);
      key_n = 4'b1111;
      tick(5);
      chk("t1_held_rel_e13", 32'(key_held), 1);
      tick();
      chk("t1_held_rel_e14", 32'(key_held), 0);
      tick(4);
      chk("t1_acc",  32'(n_acc),     1);
      chk("t1_last", 32'(last_code), 1);

      // 2: bounce rejection, then a real press of key 0
      key_n = 4'b1110; tick(3);
      key_n = 4'b1111; tick(1);
      key_n = 4'b1110; tick(3);
      key_n = 4'b1111; tick(8);
      chk("t2_bounce_held", 32'(key_held), 0);
      chk("t2_bounce_acc",  32'(n_acc),    1);
      key_n = 4'b1110; tick(6);
      key_n = 4'b1111; tick(1);
      chk("t2_valid_e7", 32'(kif.key_valid), 1);
      chk("t2_code_e7",  32'(kif.key_code),  0);
      tick(12);
      chk("t2_acc",  32'(n_acc),     2);
      chk("t2_last", 32'(last_code), 0);
      chk("t2_held", 32'(key_held),  0);

      // 3: stall with key 2 pending, key 3 press is dropped
      kif.key_ready = 1'b0;
      key_n = 4'b1011;
      tick(7);
      chk("t3_valid_e7", 32'(kif.key_valid), 1);
      chk("t3_code_e7",  32'(kif.key_code),  2);
      tick(1);
      key_n = 4'b1111;
      tick(8);
      key_n = 4'b0111;
      tick(6);
      chk("t3_drop_pre",  32'(dropped),       0);
      tick();
      chk("t3_drop",      32'(dropped),       1);
      chk("t3_valid_hold",32'(kif.key_valid), 1);
      chk("t3_code_hold", 32'(kif.key_code),  2);
      tick();
      chk("t3_drop_post", 32'(dropped),       0);
      key_n = 4'b1111;
      kif.key_ready = 1'b1;
      tick();
      chk("t3_valid_fall", 32'(kif.key_valid), 0);
      tick(12);
      chk("t3_valid_quiet", 32'(kif.key_valid), 0);
      chk("t3_acc",  32'(n_acc),     3);
      chk("t3_last", 32'(last_code), 2);

      // 4: back-to-back accept, code 1 -> 3 without a bubble
      kif.key_ready = 1'b0;
      key_n = 4'b1101;
      tick(8);
      chk("t4_valid_e8", 32'(kif.key_valid), 1);
      chk("t4_code_e8",  32'(kif.key_code),  1);
      key_n = 4'b0101;
      tick(6);
      chk("t4_code_e14", 32'(kif.key_code), 1);
      kif.key_ready = 1'b1;
      tick();
      chk("t4_valid_e15", 32'(kif.key_valid), 1);
      chk("t4_code_e15",  32'(kif.key_code),  3);
      chk("t4_drop_e15",  32'(dropped),       0);
      tick();
      chk("t4_valid_e16", 32'(kif.key_valid), 0);
      key_n = 4'b1111;
      tick(12);
      chk("t4_acc",  32'(n_acc),     5);
      chk("t4_last", 32'(last_code), 3);

      // 5: keys 1 and 2 pressed together
      key_n = 4'b1001;
      tick(6);
      chk("t5_valid_e6", 32'(kif.key_valid), 0);
      chk("t5_drop_e6",  32'(dropped),       0);
      tick();
      chk("t5_valid_e7", 32'(kif.key_valid), 1);
      chk("t5_code_e7",  32'(kif.key_code),  1);
      chk("t5_drop_e7",  32'(dropped),       1);
      tick();
      chk("t5_drop_e8",  32'(dropped),       0);
      key_n = 4'b1111;
      tick(12);
      chk("t5_acc",  32'(n_acc),     6);
      chk("t5_last", 32'(last_code), 1);

      // 6: asynchronous reset while key 0 is pending and still held
      kif.key_ready = 1'b0;
      key_n = 4'b1110;
      tick(8);
      chk("t6_valid_pre", 32'(kif.key_valid), 1);
      chk("t6_held_pre",  32'(key_held),      1);
      #2 reset = 1'b0;
      #1;
      chk("t6_valid_rst", 32'(kif.key_valid), 0);
      chk("t6_held_rst",  32'(key_held),      0);
      tick();
      reset = 1'b1;
      tick(6);
      chk("t6_valid_r6", 32'(kif.key_valid), 0);
      chk("t6_held_r6",  32'(key_held),      1);
      tick();
      chk("t6_valid_r7", 32'(kif.key_valid), 1);
      chk("t6_code_r7",  32'(kif.key_code),  0);
      tick(2);
      chk("t6_acc", 32'(n_acc), 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
